event_readout: RTL and testbench

Downstream readout stage for the sampler's event FIFO, in the f125_clk domain. Pops 64-bit sample words from the FIFO read port, splits each word into two 32-bit beats (low half first) and presents them on a valid/ready stream toward the DMA/host link. Frames each event of WORDS_PER_EVENT FIFO words with a last flag and keeps a running event count.

---
 rtl/event_readout_if.sv | 20 ++
 rtl/event_readout.sv | 134 +++++++++++++
 tb/tb_event_readout.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/event_readout_if.sv
// FIFO read port plus 32-bit valid/ready stream between event_readout and its neighbours.
interface event_readout_if;
  logic [63:0] dout_i;
  logic        empty_i;
  logic        rd_en_o;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    input  dout_i, empty_i, m_tready,
    output rd_en_o, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output dout_i, empty_i, m_tready,
    input  rd_en_o, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/event_readout.sv
// Pops 64-bit FIFO words, emits them as two 32-bit beats (low first), frames events with tlast.
// Optional per-event header beat {16'hEB90, count} when EVENT_HEADER_EN is defined.
module event_readout #(
  parameter int WORDS_PER_EVENT = 16,
  parameter int CNT_W           = 16
) (
  input  logic             f125_clk,
  input  logic             aresetn,
  event_readout_if.master  bus,
  output logic [CNT_W-1:0] event_count_o,
  output logic             busy_o
);
  localparam int WC_W = (WORDS_PER_EVENT > 1) ? $clog2(WORDS_PER_EVENT + 1) : 1;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(WORDS_PER_EVENT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef EVENT_HEADER_EN
    S_HDR,
`endif
    S_FETCH,
    S_WAIT,
    S_LO,
    S_HI
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      hold_q, hold_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wcnt_d   = wcnt_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      S_IDLE: begin
        wcnt_d = '0;
        if (!bus.empty_i) begin
`ifdef EVENT_HEADER_EN
          state_d  = S_HDR;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
`else
          state_d  = S_FETCH;
`endif
        end
      end
`ifdef EVENT_HEADER_EN
      S_HDR: begin
        if (bus.m_tready) begin
          state_d  = S_FETCH;
          tvalid_d = 1'b0;
        end
      end
`endif
      S_FETCH: begin
        if (!bus.empty_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        hold_d   = bus.dout_i;
        state_d  = S_LO;
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
      end
      S_LO: begin
        if (bus.m_tready) begin
          state_d = S_HI;
          tlast_d = (wcnt_q == LAST_IDX);
        end
      end
      S_HI: begin
        if (bus.m_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
          end else begin
            wcnt_d  = wcnt_q + WC_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge f125_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wcnt_q   <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wcnt_q   <= wcnt_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  // Data is a pure mux of registered state, so it cannot move while a beat is stalled.
  always_comb begin
    bus.m_tdata = '0;
    case (state_q)
`ifdef EVENT_HEADER_EN
      S_HDR:   bus.m_tdata = {16'hEB90, 16'(cnt_q)};
`endif
      S_LO:    bus.m_tdata = hold_q[31:0];
      S_HI:    bus.m_tdata = hold_q[63:32];
      default: bus.m_tdata = '0;
    endcase
  end

  assign bus.rd_en_o   = (state_q == S_FETCH) & ~bus.empty_i;
  assign bus.m_tvalid  = tvalid_q;
  assign bus.m_tlast   = tlast_q;
  assign event_count_o = cnt_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_event_readout.sv
// Randomized directed bench for event_readout (WORDS_PER_EVENT=2, CNT_W=4) with a FIFO and beat-list model.
module tb_event_readout;
  localparam int W = 2;
  localparam int CW = 4;
`ifdef EVENT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BPE = 2 * W + HDR;

  logic          f125_clk = 1'b0;
  logic          aresetn  = 1'b0;
  logic [CW-1:0] event_count_o;
  logic          busy_o;

  event_readout_if bus ();

  event_readout #(.WORDS_PER_EVENT(W), .CNT_W(CW)) dut (
    .f125_clk     (f125_clk),
    .aresetn      (aresetn),
    .bus          (bus),
    .event_count_o(event_count_o),
    .busy_o       (busy_o)
  );

  always #4 f125_clk = ~f125_clk;

  // FIFO model: src holds words in push order, released says how many are visible.
  logic [63:0] src [0:255];
  int released = 0;
  int rd_ptr   = 0;
  assign bus.empty_i = (rd_ptr >= released);
  always @(posedge f125_clk) begin
    if (bus.rd_en_o) begin
      bus.dout_i <= src[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int rmode = 0;
  int rphase = 0;
  always @(negedge f125_clk) begin
    case (rmode)
      0: bus.m_tready = 1'b1;
      1: bus.m_tready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
      default: bus.m_tready = 1'($urandom_range(0, 1));
    endcase
    rphase++;
  end

  // Beat recorder and stream-rule monitor.
  logic [31:0] mon_data [0:1023];
  logic        mon_last [0:1023];
  int nbeats = 0, rd_cnt = 0, proto_err = 0;
  logic stall_prev = 1'b0;
  logic [31:0] pd;
  logic pl;
  always @(posedge f125_clk) begin
    if (!aresetn) stall_prev = 1'b0;
    else begin
      if (stall_prev && (!bus.m_tvalid || bus.m_tdata !== pd || bus.m_tlast !== pl)) proto_err++;
      if (bus.rd_en_o && bus.empty_i) proto_err++;
      if (bus.rd_en_o) rd_cnt++;
      if (bus.m_tvalid && bus.m_tready) begin
        mon_data[nbeats] = bus.m_tdata;
        mon_last[nbeats] = bus.m_tlast;
        nbeats++;
      end
      stall_prev = bus.m_tvalid && !bus.m_tready;
      pd = bus.m_tdata;
      pl = bus.m_tlast;
    end
  end

  int n_asrt = 0, n_fail = 0;
  int cons = 0, base = 0, exp_cnt = 0, rd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] exp_beat(input int j, input int cnt, input int b);
    logic [63:0] w;
    int k;
    if (HDR == 1 && j == 0) return {1'b0, 16'hEB90, 16'(cnt % 16)};
    k = j - HDR;
    w = src[b + k / 2];
    return {(j == BPE - 1), ((k % 2) == 1) ? w[63:32] : w[31:0]};
  endfunction

  task automatic expect_event();
    int to = 0;
    logic [32:0] e;
    while (nbeats < cons + BPE && to < 3000) begin
      @(negedge f125_clk);
      to++;
    end
    check("evt_timeout", 64'(nbeats >= cons + BPE), 64'd1);
    if (nbeats >= cons + BPE) begin
      for (int j = 0; j < BPE; j++) begin
        e = exp_beat(j, exp_cnt, base);
        check($sformatf("beat%0d_data", j), 64'(mon_data[cons + j]), 64'(e[31:0]));
        check($sformatf("beat%0d_last", j), 64'(mon_last[cons + j]), 64'(e[32]));
      end
      cons += BPE;
      base += W;
      exp_cnt = (exp_cnt + 1) % 16;
      check("event_count", 64'(event_count_o), 64'(exp_cnt));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"},  64'(bus.rd_en_o),  64'd0);
    check({tag, "_tvalid"}, 64'(bus.m_tvalid), 64'd0);
    check({tag, "_tlast"},  64'(bus.m_tlast),  64'd0);
    check({tag, "_tdata"},  64'(bus.m_tdata),  64'd0);
    check({tag, "_count"},  64'(event_count_o), 64'd0);
    check({tag, "_busy"},   64'(busy_o),       64'd0);
  endtask

  initial begin
    int to;
    repeat (2) @(negedge f125_clk);
    check_idle_outputs("reset");
    aresetn = 1'b1;
    @(negedge f125_clk);

    // Basic event from a preloaded FIFO, plus first-beat latency.
    src[0] = 64'h1111_2222_3333_4444;
    src[1] = 64'h5555_6666_7777_8888;
    rd0 = rd_cnt;
    released = 2;
    @(negedge f125_clk);
    check("lat1_busy", 64'(busy_o), 64'd1);
`ifdef EVENT_HEADER_EN
    check("lat1_hdr_valid", 64'(bus.m_tvalid), 64'd1);
    check("lat1_hdr_data", 64'(bus.m_tdata), 64'hEB90_0000);
`else
    check("lat1_rd_en", 64'(bus.rd_en_o), 64'd1);
    check("lat1_valid", 64'(bus.m_tvalid), 64'd0);
    @(negedge f125_clk);
    check("lat2_valid", 64'(bus.m_tvalid), 64'd0);
    @(negedge f125_clk);
    check("lat3_valid", 64'(bus.m_tvalid), 64'd1);
    check("lat3_data", 64'(bus.m_tdata), 64'h3333_4444);
`endif
    expect_event();
    check("A_rd_pulses", 64'(rd_cnt - rd0), 64'd2);

    // Same data under a 1,0,0,1 ready pattern.
    src[2] = src[0];
    src[3] = src[1];
    rmode = 1;
    rd0 = rd_cnt;
    released = 4;
    expect_event();
    check("B_rd_pulses", 64'(rd_cnt - rd0), 64'd2);
    check("B_proto", 64'(proto_err), 64'd0);

    // FIFO runs dry mid-event: block must stall in FETCH.
    rmode = 0;
    src[4] = {$urandom, $urandom};
    src[5] = {$urandom, $urandom};
    released = 5;
    to = 0;
    while (nbeats < cons + HDR + 2 && to < 200) begin
      @(negedge f125_clk);
      to++;
    end
    check("C_first_word_timeout", 64'(nbeats >= cons + HDR + 2), 64'd1);
    repeat (10) begin
      @(negedge f125_clk);
      check("C_stall_valid", 64'(bus.m_tvalid), 64'd0);
      check("C_stall_rd_en", 64'(bus.rd_en_o), 64'd0);
    end
    released = 6;
    expect_event();

    // Random data and ready; count wraps 15 -> 0 -> 1 along the way.
    rmode = 2;
    for (int e = 0; e < 15; e++) begin
      src[released]     = {$urandom, $urandom};
      src[released + 1] = {$urandom, $urandom};
      released += 2;
      expect_event();
    end
    check("R_proto", 64'(proto_err), 64'd0);

    // Reset during the first data beat: popped word is lost, a fresh event follows.
    rmode = 0;
    for (int i = 0; i < 3; i++) src[released + i] = {$urandom, $urandom};
    released += 3;
    to = 0;
    while (nbeats < cons + HDR && to < 200) begin
      @(negedge f125_clk);
      to++;
    end
    @(negedge f125_clk);
    while (!bus.m_tvalid && to < 200) begin
      @(negedge f125_clk);
      to++;
    end
    check("X_lo_timeout", 64'(bus.m_tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge f125_clk);
    aresetn = 1'b1;
    cons = nbeats;
    base += 1;
    exp_cnt = 0;
    expect_event();
    check("final_proto", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
